// File: rtl/servo_instr_scheduler_if.sv
// ----------------------------------------------------------------------------
// servo_instr_scheduler_if
// Dispatch bus between the instruction scheduler and the per-servo PWM
// position registers.
//   cmd_valid   : FIFO head holds a command
//   cmd_servo   : servo index of the FIFO head
//   cmd_pos     : position of the FIFO head
//   servo_ready : per-channel "can accept a position"
//   servo_load  : one-hot load strobe to the addressed, ready channel
// master = scheduler side, slave = servo channel side.
// ----------------------------------------------------------------------------
interface servo_instr_scheduler_if #(
    parameter int SERVO_W = 2,
    parameter int POS_W   = 8
);
    localparam int NUM_SERVOS = 2 ** SERVO_W;

    logic                  cmd_valid;
    logic [SERVO_W-1:0]    cmd_servo;
    logic [POS_W-1:0]      cmd_pos;
    logic [NUM_SERVOS-1:0] servo_ready;
    logic [NUM_SERVOS-1:0] servo_load;

    modport master (
        output cmd_valid, cmd_servo, cmd_pos, servo_load,
        input  servo_ready
    );

    modport slave (
        input  cmd_valid, cmd_servo, cmd_pos, servo_load,
        output servo_ready
    );
endinterface

// File: rtl/servo_instr_scheduler.sv
// ----------------------------------------------------------------------------
// servo_instr_scheduler
// Synchronises the MBED serial data/strobe pins, assembles MSB-first
// instruction frames (servo index followed by position) with an idle timeout
// that recovers framing, queues decoded commands in a first-word-fall-through
// FIFO and dispatches the head to its servo channel via ready/load.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : accept incoming bit strobes
//   clear        : synchronous flush of the partial frame and the FIFO
//   set_bit      : MBED data bit (asynchronous)
//   confirm_bit  : MBED bit strobe (asynchronous, rising edge = bit valid)
//   bus          : dispatch bus (cmd_valid/cmd_servo/cmd_pos/servo_ready/
//                  servo_load), master side
//   frame_done   : 1-cycle pulse, frame pushed into the FIFO
//   overflow     : 1-cycle pulse, frame dropped because the FIFO was full
//   timeout_err  : 1-cycle pulse, partial frame discarded after idle timeout
//   parity_err   : 1-cycle pulse, frame failed odd parity (only with
//                  SERVO_INSTR_PARITY_EN)
//   busy         : frame in progress or a command is waiting
//
// Optional feature macro: SERVO_INSTR_PARITY_EN appends an odd-parity bit to
// every frame and adds the parity_err output.
// ----------------------------------------------------------------------------
module servo_instr_scheduler #(
    parameter int SERVO_W     = 2,
    parameter int POS_W       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 65535,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    input  logic set_bit,
    input  logic confirm_bit,
    servo_instr_scheduler_if.master bus,
    output logic frame_done,
    output logic overflow,
    output logic timeout_err,
`ifdef SERVO_INSTR_PARITY_EN
    output logic parity_err,
`endif
    output logic busy
);
    localparam int NUM_SERVOS = 2 ** SERVO_W;
    localparam int INSTR_W    = SERVO_W + POS_W;
`ifdef SERVO_INSTR_PARITY_EN
    localparam int FRAME_W    = INSTR_W + 1;
`else
    localparam int FRAME_W    = INSTR_W;
`endif
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int BCNT_W     = $clog2(FRAME_W + 1);
    localparam int TMR_W      = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

    logic [SYNC_STAGES-1:0] set_sync_q,  set_sync_d;
    logic [SYNC_STAGES:0]   conf_sync_q, conf_sync_d;
    logic [SYNC_STAGES:0]   set_chain;
    logic [SYNC_STAGES+1:0] conf_chain;
    logic                   strobe_q, strobe_d, bit_q, bit_d;
    state_e                 state_q, state_d;
    logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [INSTR_W-1:0]     mem_q [FIFO_DEPTH];
    logic [INSTR_W-1:0]     mem_d [FIFO_DEPTH];
    logic [INSTR_W-1:0]     head, instr;
    logic                   frame_done_q, frame_done_d;
    logic                   overflow_q, overflow_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   strobe, push, pop, frame_ok;
`ifdef SERVO_INSTR_PARITY_EN
    logic                   parity_err_q, parity_err_d;
`endif

    // The extra conf stage holds the previous synchronised level for edge detect;
    // the top set stage is the synchronised data aligned with it.
    assign set_chain  = {set_sync_q, set_bit};
    assign conf_chain = {conf_sync_q, confirm_bit};

    assign strobe = strobe_q & enable;
    assign instr  = shift_q[FRAME_W-1 -: INSTR_W];
`ifdef SERVO_INSTR_PARITY_EN
    assign frame_ok = ^shift_q;   // odd parity over data plus parity bit
`else
    assign frame_ok = 1'b1;
`endif

    // Head outputs are forced to zero when empty so unwritten storage never leaks out.
    assign head           = mem_q[rd_ptr_q];
    assign bus.cmd_valid  = (fifo_cnt_q != '0);
    assign bus.cmd_servo  = bus.cmd_valid ? head[INSTR_W-1:POS_W] : '0;
    assign bus.cmd_pos    = bus.cmd_valid ? head[POS_W-1:0] : '0;
    assign bus.servo_load = {NUM_SERVOS{bus.cmd_valid}} & bus.servo_ready
                            & (NUM_SERVOS'(1) << bus.cmd_servo);
    assign pop            = |bus.servo_load;

    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;
`ifdef SERVO_INSTR_PARITY_EN
    assign parity_err  = parity_err_q;
`endif
    assign busy        = (state_q != IDLE) | bus.cmd_valid;

    always_comb begin
        set_sync_d    = set_chain[SYNC_STAGES-1:0];
        conf_sync_d   = conf_chain[SYNC_STAGES:0];
        strobe_d      = conf_chain[SYNC_STAGES] & ~conf_chain[SYNC_STAGES+1];
        bit_d         = set_chain[SYNC_STAGES];
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        timer_d       = timer_q;
        shift_d       = shift_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        mem_d         = mem_q;
        frame_done_d  = 1'b0;
        overflow_d    = 1'b0;
        timeout_err_d = 1'b0;
`ifdef SERVO_INSTR_PARITY_EN
        parity_err_d  = 1'b0;
`endif
        push          = 1'b0;

        case (state_q)
            SHIFT: begin
                if (strobe) begin
                    shift_d = {shift_q[FRAME_W-2:0], bit_q};
                    bcnt_d  = bcnt_q + BCNT_W'(1);
                    timer_d = TMR_W'(1);   // timer counts clocks since the last strobe
                    if (bcnt_d == BCNT_W'(FRAME_W)) state_d = COMMIT;
                end else if (timer_q + TMR_W'(1) == TMR_W'(TIMEOUT)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                    bcnt_d        = '0;
                    timer_d       = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            COMMIT: begin
                if (!frame_ok) begin
`ifdef SERVO_INSTR_PARITY_EN
                    parity_err_d = 1'b1;
`endif
                end else if (fifo_cnt_q != CNT_W'(FIFO_DEPTH) || pop) begin
                    push         = 1'b1;
                    frame_done_d = 1'b1;
                end else begin
                    overflow_d   = 1'b1;
                end
                state_d = IDLE;
                bcnt_d  = '0;
                timer_d = '0;
                // A strobe landing on the commit cycle opens the next frame.
                if (strobe) begin
                    shift_d = {shift_q[FRAME_W-2:0], bit_q};
                    bcnt_d  = BCNT_W'(1);
                    timer_d = TMR_W'(1);
                    state_d = SHIFT;
                end
            end
            default: begin
                timer_d = '0;
                if (strobe) begin
                    shift_d = {shift_q[FRAME_W-2:0], bit_q};
                    bcnt_d  = BCNT_W'(1);
                    timer_d = TMR_W'(1);
                    state_d = SHIFT;
                end
            end
        endcase

        // With a full FIFO a simultaneous pop frees rd_ptr's slot, which equals wr_ptr.
        if (push) begin
            mem_d[wr_ptr_q] = instr;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);

        if (clear) begin
            state_d       = IDLE;
            bcnt_d        = '0;
            timer_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            fifo_cnt_d    = '0;
            frame_done_d  = 1'b0;
            overflow_d    = 1'b0;
            timeout_err_d = 1'b0;
`ifdef SERVO_INSTR_PARITY_EN
            parity_err_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_sync_q    <= '0;
            conf_sync_q   <= '0;
            strobe_q      <= 1'b0;
            state_q       <= IDLE;
            bcnt_q        <= '0;
            timer_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef SERVO_INSTR_PARITY_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            set_sync_q    <= set_sync_d;
            conf_sync_q   <= conf_sync_d;
            strobe_q      <= strobe_d;
            state_q       <= state_d;
            bcnt_q        <= bcnt_d;
            timer_q       <= timer_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
`ifdef SERVO_INSTR_PARITY_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    // Datapath storage carries no reset; it is only observed once written.
    always_ff @(posedge clk) begin
        bit_q   <= bit_d;
        shift_q <= shift_d;
        mem_q   <= mem_d;
    end
endmodule

// File: tb/tb_servo_instr_scheduler.sv
module tb_servo_instr_scheduler;
    localparam int SERVO_W     = 2;
    localparam int POS_W       = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT     = 100;
    localparam int SYNC_STAGES = 2;
`ifdef SERVO_INSTR_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic set_bit = 1'b0;
    logic confirm_bit = 1'b0;
    logic frame_done, overflow, timeout_err, busy;
`ifdef SERVO_INSTR_PARITY_EN
    logic parity_err;
`endif

    servo_instr_scheduler_if #(.SERVO_W(SERVO_W), .POS_W(POS_W)) bus_if ();

    servo_instr_scheduler #(
        .SERVO_W(SERVO_W), .POS_W(POS_W), .FIFO_DEPTH(FIFO_DEPTH),
        .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .set_bit(set_bit), .confirm_bit(confirm_bit), .bus(bus_if),
        .frame_done(frame_done), .overflow(overflow), .timeout_err(timeout_err),
`ifdef SERVO_INSTR_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Event recorder: pulse counts and every cycle that carried a load.
    int cyc = 0, n_fd = 0, n_ov = 0, n_to = 0, n_pe = 0, n_ld = 0;
    logic [3:0] ld_mask [1024];
    int ld_servo [1024];
    int ld_pos [1024];
    int ld_cyc [1024];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (frame_done)  n_fd <= n_fd + 1;
            if (overflow)    n_ov <= n_ov + 1;
            if (timeout_err) n_to <= n_to + 1;
`ifdef SERVO_INSTR_PARITY_EN
            if (parity_err)  n_pe <= n_pe + 1;
`endif
            if (|bus_if.servo_load) begin
                ld_mask[n_ld]  <= bus_if.servo_load;
                ld_servo[n_ld] <= int'(bus_if.cmd_servo);
                ld_pos[n_ld]   <= int'(bus_if.cmd_pos);
                ld_cyc[n_ld]   <= cyc;
                n_ld <= n_ld + 1;
            end
        end
    end

    int vectors = 0, miscompares = 0;
    int rd_ld = 0;
    int fd0, ov0, to0, pe0;
    int exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        fd0 = n_fd; ov0 = n_ov; to0 = n_to; pe0 = n_pe;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        set_bit = b;
        confirm_bit = 1'b1;
        tick(4);
        confirm_bit = 1'b0;
        tick(15);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
    endtask

    task automatic send_frame(input int servo, input int pos);
        logic [10:0] f;
        f = {servo[1:0], pos[7:0], 1'b0};
        if (PAR) begin
            f[0] = ~^f[10:1];
            send_bits({5'b0, f}, 11);
        end else begin
            send_bits({6'b0, f[10:1]}, 10);
        end
    endtask

    task automatic expect_load(input string tag, input int servo, input int pos);
        check({tag, " load_present"}, 32'(n_ld > rd_ld), 32'd1);
        if (n_ld > rd_ld) begin
            check({tag, " load_mask"}, 32'(ld_mask[rd_ld]), 32'd1 << servo);
            check({tag, " load_servo"}, ld_servo[rd_ld], servo);
            check({tag, " load_pos"}, ld_pos[rd_ld], pos);
            rd_ld++;
        end
    endtask

    task automatic expect_no_more_loads(input string tag);
        check({tag, " extra_loads"}, n_ld - rd_ld, 0);
        rd_ld = n_ld;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cmd_valid"}, 32'(bus_if.cmd_valid), 0);
        check({tag, " cmd_servo"}, 32'(bus_if.cmd_servo), 0);
        check({tag, " cmd_pos"}, 32'(bus_if.cmd_pos), 0);
        check({tag, " servo_load"}, 32'(bus_if.servo_load), 0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
        check({tag, " overflow"}, 32'(overflow), 0);
        check({tag, " timeout_err"}, 32'(timeout_err), 0);
        check({tag, " busy"}, 32'(busy), 0);
`ifdef SERVO_INSTR_PARITY_EN
        check({tag, " parity_err"}, 32'(parity_err), 0);
`endif
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: observed no completion, expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, p, k, i0, r, n;
        bus_if.servo_ready = '0;
        enable = 1'b1;
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(3);

        // Single frame, servo 1 ready: one load then empty.
        bus_if.servo_ready = 4'b0010;
        snap();
        send_frame(1, 'hB3);
        tick(3);
        check("t1 frame_done", n_fd - fd0, 1);
        expect_load("t1", 1, 'hB3);
        expect_no_more_loads("t1");
        check("t1 cmd_valid_after", 32'(bus_if.cmd_valid), 0);
        check("t1 overflow", n_ov - ov0, 0);

        // Five random frames into a blocked FIFO, then drain in order.
        bus_if.servo_ready = '0;
        snap();
        exp_q.delete();
        k = 0;
        for (int i = 0; i < 5; i++) begin
            s = $urandom_range(0, 3);
            p = $urandom_range(0, 255);
            send_frame(s, p);
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(s * 256 + p);
            else k++;
        end
        tick(3);
        check("t2 frame_done", n_fd - fd0, exp_q.size());
        check("t2 overflow", n_ov - ov0, k);
        check("t2 head_servo", 32'(bus_if.cmd_servo), exp_q[0] / 256);
        check("t2 head_pos", 32'(bus_if.cmd_pos), exp_q[0] % 256);
        expect_no_more_loads("t2 blocked");
        bus_if.servo_ready = 4'hF;
        tick(8);
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            expect_load("t2 drain", s / 256, s % 256);
        end
        expect_no_more_loads("t2");
        check("t2 cmd_valid_after", 32'(bus_if.cmd_valid), 0);
        check("t2 busy_after", 32'(busy), 0);

        // Random head-of-line rounds against the queue model.
        for (int rnd = 0; rnd < 3; rnd++) begin
            bus_if.servo_ready = '0;
            exp_q.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                s = $urandom_range(0, 3);
                p = $urandom_range(0, 255);
                send_frame(s, p);
                exp_q.push_back(s * 256 + p);
            end
            r = $urandom_range(0, 15);
            bus_if.servo_ready = 4'(r);
            tick(8);
            while (exp_q.size() > 0 && r[exp_q[0] / 256]) begin
                s = exp_q.pop_front();
                expect_load("rnd partial", s / 256, s % 256);
            end
            expect_no_more_loads("rnd partial");
            check("rnd cmd_valid", 32'(bus_if.cmd_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                check("rnd head_servo", 32'(bus_if.cmd_servo), exp_q[0] / 256);
            bus_if.servo_ready = 4'hF;
            tick(8);
            while (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                expect_load("rnd drain", s / 256, s % 256);
            end
            expect_no_more_loads("rnd drain");
        end

        // Head-of-line blocking: servo 2 then servo 0 with only servo 0 ready.
        bus_if.servo_ready = 4'b0001;
        p = $urandom_range(0, 255);
        k = $urandom_range(0, 255);
        send_frame(2, p);
        send_frame(0, k);
        tick(3);
        expect_no_more_loads("t4 blocked");
        check("t4 head_servo", 32'(bus_if.cmd_servo), 2);
        bus_if.servo_ready = 4'b0101;
        tick(6);
        i0 = rd_ld;
        expect_load("t4 first", 2, p);
        expect_load("t4 second", 0, k);
        if (n_ld >= i0 + 2) check("t4 back_to_back", ld_cyc[i0 + 1] - ld_cyc[i0], 1);
        expect_no_more_loads("t4");

        // Strobes ignored while disabled.
        bus_if.servo_ready = '0;
        snap();
        enable = 1'b0;
        send_frame(1, 'h33);
        tick(3);
        enable = 1'b1;
        check("dis frame_done", n_fd - fd0, 0);
        check("dis busy", 32'(busy), 0);

        // Timeout after six bits, then a clean frame.
        snap();
        send_bits(16'b10110, 5);
        @(negedge clk);
        set_bit = 1'b1;
        confirm_bit = 1'b1;
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (k == 4) confirm_bit = 1'b0;
            if (timeout_err) break;
        end
        check("t3 timeout_latency", k, SYNC_STAGES + 1 + TIMEOUT);
        tick(3);
        check("t3 timeout_count", n_to - to0, 1);
        check("t3 frame_done", n_fd - fd0, 0);
        send_frame(3, 'h5A);
        tick(3);
        check("t3 cmd_valid", 32'(bus_if.cmd_valid), 1);
        check("t3 cmd_servo", 32'(bus_if.cmd_servo), 3);
        check("t3 cmd_pos", 32'(bus_if.cmd_pos), 'h5A);
        bus_if.servo_ready = 4'hF;
        tick(5);
        expect_load("t3", 3, 'h5A);
        expect_no_more_loads("t3");

        // clear mid-frame with two commands queued.
        bus_if.servo_ready = '0;
        send_frame($urandom_range(0, 3), $urandom_range(0, 255));
        send_frame($urandom_range(0, 3), $urandom_range(0, 255));
        send_bits(16'b1101, 4);
        snap();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5 clear cmd_valid", 32'(bus_if.cmd_valid), 0);
        check("t5 clear busy", 32'(busy), 0);
        tick(150);
        check("t5 clear timeout", n_to - to0, 0);
        check("t5 clear frame_done", n_fd - fd0, 0);
        check("t5 clear overflow", n_ov - ov0, 0);
        s = $urandom_range(0, 3);
        p = $urandom_range(0, 255);
        send_frame(s, p);
        tick(3);
        check("t5 post_clear servo", 32'(bus_if.cmd_servo), s);
        check("t5 post_clear pos", 32'(bus_if.cmd_pos), p);

        // Asynchronous reset mid-frame with a command pending.
        send_bits(16'b011, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5 async_reset");
        tick(2);
        rst_n = 1'b1;
        tick(3);
        expect_no_more_loads("t5 reset");
        bus_if.servo_ready = 4'hF;
        snap();
        s = $urandom_range(0, 3);
        p = $urandom_range(0, 255);
        send_frame(s, p);
        tick(3);
        check("t5 post_reset frame_done", n_fd - fd0, 1);
        expect_load("t5 post_reset", s, p);
        expect_no_more_loads("t5 post_reset");

`ifdef SERVO_INSTR_PARITY_EN
        // Even total -> parity error; corrected parity bit -> accepted.
        bus_if.servo_ready = '0;
        snap();
        send_bits(16'b00_00000001_1, 11);
        tick(3);
        check("t6 parity_err", n_pe - pe0, 1);
        check("t6 bad frame_done", n_fd - fd0, 0);
        check("t6 bad overflow", n_ov - ov0, 0);
        check("t6 bad cmd_valid", 32'(bus_if.cmd_valid), 0);
        send_bits(16'b00_00000001_0, 11);
        tick(3);
        check("t6 good frame_done", n_fd - fd0, 1);
        check("t6 good parity_err", n_pe - pe0, 1);
        check("t6 good cmd_pos", 32'(bus_if.cmd_pos), 'h01);
        check("t6 good cmd_servo", 32'(bus_if.cmd_servo), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/servo_instr_scheduler.md
Name: servo_instr_scheduler

Overview:
Clocked front end and dispatcher for MBED-issued servo instructions. It synchronises the MBED serial bit and confirm lines, assembles fixed-width instruction frames with a timeout to recover framing, and queues decoded commands in a small FIFO. It dispatches each command to the addressed servo channel using a per-channel ready/load handshake. It sits between the MBED pins and the per-servo PWM position registers.

Parameters:
SERVO_W, 2, servo index field width; NUM_SERVOS = 2**SERVO_W
POS_W, 8, position field width; INSTR_W = SERVO_W + POS_W (default 10)
FIFO_DEPTH, 4, queued commands; power of two, minimum 2
TIMEOUT, 65535, idle clocks after the last bit before a partial frame is discarded
SYNC_STAGES, 2, synchroniser flops on set_bit and confirm_bit

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
enable  in  1  high to accept incoming bits
clear  in  1  synchronous flush of frame and FIFO
set_bit  in  1  MBED data bit, asynchronous
confirm_bit  in  1  MBED bit strobe, asynchronous; rising edge = bit valid
servo_ready  in  NUM_SERVOS  channel i can accept a position
cmd_valid  out  1  FIFO head valid
cmd_servo  out  SERVO_W  FIFO head servo index
cmd_pos  out  POS_W  FIFO head position
servo_load  out  NUM_SERVOS  one-hot load strobe to channel cmd_servo
frame_done  out  1  1-cycle pulse: frame pushed into the FIFO
overflow  out  1  1-cycle pulse: frame dropped because the FIFO was full
timeout_err  out  1  1-cycle pulse: partial frame discarded
busy  out  1  FSM not in IDLE, or cmd_valid high

Behaviour:
- Reset (rst_n low, asynchronous): FSM = IDLE; bit counter, timer and FIFO cleared. Every output is 0.
- Synchronisation: set_bit and confirm_bit each pass through SYNC_STAGES flops.
  - A bit strobe is a rising edge of the synchronised confirm_bit.
  - The data bit is the synchronised set_bit in the strobe cycle.
  - Latency from the confirm_bit pin edge to the strobe is SYNC_STAGES+1 clocks.
- Strobes are ignored while enable is 0. The timer keeps running regardless of enable.
- Frame format: MSB-first, INSTR_W bits. instr[INSTR_W-1:POS_W] is the servo index; instr[POS_W-1:0] is the position.
- FSM:
  - IDLE: a strobe shifts in the first bit, sets cnt=1, goes to SHIFT.
  - SHIFT: each strobe shifts one bit, increments cnt and zeroes the timer. The strobe that makes cnt==INSTR_W moves the FSM to COMMIT. Timer reaching TIMEOUT: pulse timeout_err, discard shift data, go to IDLE.
  - COMMIT (1 cycle):
    - FIFO not full, or a pop occurs in the same cycle: push the frame and pulse frame_done.
    - Otherwise: drop the frame and pulse overflow.
    - Next state is IDLE. A strobe arriving in the COMMIT cycle is taken as bit 1 of the next frame.
- FIFO: first-word-fall-through.
  - cmd_valid/cmd_servo/cmd_pos are registered and appear 1 clock after a push into an empty FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
- Dispatch: servo_load[i] = cmd_valid & (cmd_servo==i) & servo_ready[i], combinational from registered head plus ready. A load pops the FIFO in the same cycle; the next head is visible on the following clock.
- Ordering is strict, with head-of-line blocking: a command for a non-ready servo stalls all later commands.
- clear: synchronous, highest priority below reset.
  - FSM goes to IDLE; cnt, timer and FIFO are cleared.
  - cmd_valid and servo_load are 0 from the next clock.
  - No error pulses are generated.
- Reset or clear mid-frame: the partial frame is lost. The next strobe starts a new frame.

Optional Feature:
Macro SERVO_INSTR_PARITY_EN.
- Defined:
  - Frame is INSTR_W+1 bits; the last bit is odd parity over all INSTR_W+1 bits.
  - Extra output parity_err (1 bit, reset 0) pulses in COMMIT on a mismatch; that frame is neither pushed nor counted as overflow.
- Undefined: INSTR_W-bit frames, no parity_err port.

Test Plan:
1. Reset, then send 10'b01_10110011 with strobes 20 clks apart and servo_ready=4'b0010 -> frame_done pulse; cmd_valid=1 with cmd_servo=1, cmd_pos=8'hB3; servo_load=4'b0010 for exactly 1 clk; cmd_valid drops the next clk.
2. servo_ready=0, send 5 frames -> frame_done x4, overflow on the 5th. Set servo_ready=4'hF -> four servo_load pulses in send order, then cmd_valid=0.
3. TIMEOUT=100: send 6 bits, then idle -> timeout_err exactly 100 clks after the last strobe. A following full frame (servo 3, 8'h5A) decodes correctly.
4. Queue servo 2 then servo 0 with servo_ready=4'b0001 -> no load. Raise servo_ready[2] -> load 4'b0100, then 4'b0001 on the next valid cycle.
5. Assert clear mid-frame with 2 commands queued -> cmd_valid=0 next clk, no pulses. Deassert rst_n mid-frame -> all outputs 0 immediately. A subsequent frame decodes cleanly.
6. With SERVO_INSTR_PARITY_EN, send 11'b00_00000001_1 (even total) -> parity_err pulse, no frame_done. Corrected parity bit 0 -> frame_done, cmd_pos=8'h01.
